// File: rtl/barrel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_pkg : shared types for the barrel shifter command sequencer. Rev 1.0
// ---------------------------------------------------------------------------
package barrel_pkg;

  localparam int DATA_W = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [2:0]        amt;
    logic              rot;
  } shift_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    OUT   = 2'd2
  } state_t;

  // Right shift of d by amt; the upper half supplies either a copy of d (rotate) or zeros.
  function automatic logic [DATA_W-1:0] shift_right(input logic [DATA_W-1:0] d,
                                                    input logic [2:0]        amt,
                                                    input logic              rot);
    logic [2*DATA_W-1:0] wide;
    wide = {(rot ? d : {DATA_W{1'b0}}), d} >> amt;
    return wide[DATA_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/barrel_cmd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_cmd_fifo : synchronous FIFO of shift commands. Rev 1.0
// ---------------------------------------------------------------------------
module barrel_cmd_fifo
  import barrel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  shift_cmd_t    wr_cmd,
  input  logic          pop,
  output shift_cmd_t    rd_cmd,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = CW - 1;

  shift_cmd_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are log2(DEPTH) bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_cmd;
  end

  assign rd_cmd = mem[rd_ptr];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

endmodule
`default_nettype wire

// File: rtl/barrel_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// barrel_seq : registered command sequencer around an external 8-bit barrel
// shifter. Optional result self-check under BARREL_SEQ_CHECK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module barrel_seq
  import barrel_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_amt,
  input  logic              in_rot,
  output logic [DATA_W-1:0] sh_i,
  output logic [2:0]        sh_select,
  output logic              sh_ctrl,
  input  logic [DATA_W-1:0] sh_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              err
);

  state_t     state;
  state_t     state_nx;
  shift_cmd_t in_cmd;
  shift_cmd_t head;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign in_cmd.data = in_data;
  assign in_cmd.amt  = in_amt;
  assign in_cmd.rot  = in_rot;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  barrel_cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_cmd (in_cmd),
    .pop    (pop),
    .rd_cmd (head),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = DRIVE;
        end
      end
      DRIVE: state_nx = OUT;
      OUT: begin
        if (out_ready) begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = DRIVE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shifter drives move only on a pop; the result is captured after one full settle cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_i      <= '0;
      sh_select <= '0;
      sh_ctrl   <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (pop) begin
        sh_i      <= head.data;
        sh_select <= head.amt;
        sh_ctrl   <= head.rot;
      end
      if (state == DRIVE) begin
        out_data  <= sh_out;
        out_valid <= 1'b1;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) || (count != '0);

`ifdef BARREL_SEQ_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (state == DRIVE && shift_right(sh_i, sh_select, sh_ctrl) != sh_out) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_barrel_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_barrel_seq : self-checking bench for barrel_seq with an attached shifter model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_barrel_seq;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef BARREL_SEQ_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_rot = 1'b0;
  logic          out_ready = 1'b0;
  logic [7:0]    in_data = '0;
  logic [2:0]    in_amt = '0;
  logic          corrupt = 1'b0;
  logic          in_ready, sh_ctrl, out_valid, busy, err;
  logic [7:0]    sh_i, sh_out, out_data;
  logic [2:0]    sh_select;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  int res_cnt = 0;

  always #5 clk = ~clk;

  barrel_seq #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_rot    (in_rot),
    .sh_i      (sh_i),
    .sh_select (sh_select),
    .sh_ctrl   (sh_ctrl),
    .sh_out    (sh_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .busy      (busy),
    .err       (err)
  );

  // Shift reference by arithmetic: rotate = divide a doubled copy of the word.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int amt, input logic rot);
    int v;
    v = int'(d);
    if (rot) v = v * 256 + int'(d);
    v = v / (1 << amt);
    return 8'(v % 256);
  endfunction

  always_comb sh_out = ref_shift(sh_i, int'(sh_select), sh_ctrl) ^ {7'b0, corrupt};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sh_i", 32'(sh_i), 32'd0);
    check("rst_sh_select", 32'(sh_select), 32'd0);
    check("rst_sh_ctrl", 32'(sh_ctrl), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic set_cmd(input logic [7:0] d, input logic [2:0] a, input logic r);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_rot   = r;
  endtask

  // Push one command, waiting (bounded) for room.
  task automatic push_cmd(input logic [7:0] d, input logic [2:0] a, input logic r);
    bit acc;
    int guard;
    set_cmd(d, a, r);
    acc   = 1'b0;
    guard = 0;
    while (!acc && guard < 50) begin
      acc = in_ready;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("push_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while (busy && i < bound) begin
      tick();
      i++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  // Scoreboard: model queue of expected results, filled on accepted pushes.
  logic [7:0] expq[$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      check("count_bound", 32'(count <= CW'(DEPTH)), 32'd1);
      if (out_valid && out_ready) begin
        res_cnt++;
        check("result_expected", 32'(expq.size() != 0), 32'd1);
        if (expq.size() != 0) check("result_order", 32'(out_data), 32'(expq.pop_front()));
      end
      if (in_valid && in_ready)
        expq.push_back(ref_shift(in_data, int'(in_amt), in_rot) ^ {7'b0, corrupt});
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       rot;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int base;
    vecs[0] = '{8'h3F, 3'd2, 1'b0, 8'h0F};
    vecs[1] = '{8'h60, 3'd4, 1'b1, 8'h06};
    vecs[2] = '{8'h43, 3'd1, 1'b1, 8'hA1};
    vecs[3] = '{8'h0C, 3'd6, 1'b1, 8'h30};
    vecs[4] = '{8'hE0, 3'd4, 1'b0, 8'h0E};
    vecs[5] = '{8'h81, 3'd0, 1'b1, 8'h81};
    vecs[6] = '{8'h81, 3'd7, 1'b0, 8'h01};
    vecs[7] = '{8'h81, 3'd7, 1'b1, 8'h03};
    vecs[8] = '{8'hFF, 3'd3, 1'b0, 8'h1F};
    vecs[9] = '{8'hA5, 3'd3, 1'b1, 8'hB4};

    tick(3);
    check_reset();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Single commands through an empty pipe: exact latency and drive hold.
    for (int i = 0; i < 10; i++) begin
      set_cmd(vecs[i].data, vecs[i].amt, vecs[i].rot);
      tick();
      in_valid = 1'b0;
      check("lat_e0_valid", 32'(out_valid), 32'd0);
      check("lat_e0_count", 32'(count), 32'd1);
      tick();
      check("drive_sh_i", 32'(sh_i), 32'(vecs[i].data));
      check("drive_sh_select", 32'(sh_select), 32'(vecs[i].amt));
      check("drive_sh_ctrl", 32'(sh_ctrl), 32'(vecs[i].rot));
      check("lat_e1_valid", 32'(out_valid), 32'd0);
      tick();
      check("lat_e2_valid", 32'(out_valid), 32'd1);
      check("vec_data", 32'(out_data), 32'(vecs[i].exp));
      check("sh_held_out", 32'(sh_select), 32'(vecs[i].amt));
      tick();
      check("consumed_valid", 32'(out_valid), 32'd0);
      check("consumed_busy", 32'(busy), 32'd0);
    end

    // Back-to-back rotates: second result two cycles after the first.
    set_cmd(8'h60, 3'd4, 1'b1);
    tick();
    set_cmd(8'h43, 3'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    check("b2b_first_data", 32'(out_data), 32'h06);
    tick();
    check("b2b_gap_valid", 32'(out_valid), 32'd0);
    tick();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_data", 32'(out_data), 32'hA1);
    drain(20);

    // Backpressure: one command in flight, four fill the FIFO, sixth refused.
    out_ready = 1'b0;
    base = res_cnt;
    for (int i = 0; i < 5; i++) begin
      set_cmd(8'($urandom), 3'($urandom), 1'($urandom));
      tick();
    end
    check("bp_count_full", 32'(count), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    set_cmd(8'h55, 3'd1, 1'b0);
    tick(3);
    check("bp_refused_count", 32'(count), 32'd4);
    check("bp_refused_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_rises", 32'(in_ready), 32'd1);
    drain(40);
    check("bp_result_count", 32'(res_cnt - base), 32'd5);

    // Continuous stream with wrap and simultaneous push/pop.
    base = res_cnt;
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0)      push_cmd(8'h0C, 3'd6, 1'b1);
      else if (i % 3 == 1) push_cmd(8'hE0, 3'd4, 1'b0);
      else                 push_cmd(8'($urandom), 3'($urandom), 1'($urandom));
    end
    drain(60);
    check("stream_result_count", 32'(res_cnt - base), 32'd12);

    // Random valid/ready traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_rot    = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain(60);
    check("random_queue_empty", 32'(expq.size()), 32'd0);

    // Reset while holding a result with three commands queued.
    out_ready = 1'b0;
    base = res_cnt;
    for (int i = 0; i < 4; i++) begin
      set_cmd(8'hF0 + 8'(i), 3'(i), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    check("mid_out_valid", 32'(out_valid), 32'd1);
    check("mid_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    tick();
    check_reset();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick(12);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_results", 32'(res_cnt - base), 32'd0);

    // Corrupted shifter result: captured as-is; err sticky when checking is built.
    corrupt = 1'b1;
    set_cmd(8'h3F, 3'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(2);
    check("corrupt_valid", 32'(out_valid), 32'd1);
    check("corrupt_data", 32'(out_data), 32'h0E);
    check("corrupt_err", 32'(err), 32'(EXP_ERR));
    tick();
    corrupt = 1'b0;
    push_cmd(8'hE0, 3'd4, 1'b0);
    tick(4);
    check("err_sticky", 32'(err), 32'(EXP_ERR));
    rst_n = 1'b0;
    tick();
    check("err_cleared", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
